// File: rtl/pc_seq_pkg.sv
// Shared encodings for the multicycle PC sequencer: FSM states, mux selects,
// ALU operations, decoded opcode/funct values and exception cause codes.
package pc_seq_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC,
    WB,
    BRANCH,
    JUMP,
    RTE,
    EXC_SAVE,
    EXC_VEC
  } state_t;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10,
    PCS_EPC    = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    SRCB_REGB = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_VEC  = 2'b10,
    SRCB_IMM  = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_PASSB = 2'b10
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_RTE = 6'h13;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_OVF     = 2'b10;

  function automatic alu_op_t alu_op_of_funct(input logic [5:0] fn);
    return (fn == FN_SUB) ? ALU_SUB : ALU_ADD;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Multicycle PC-update control FSM: MEM_LAT fetch cycles, then decode and 1-2 execute cycles; no handshakes.
// Optional PC_SEQ_EXC_COUNT_EN adds a saturating exception counter output exc_count.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int MEM_LAT       = 2,
  parameter bit WB_EN_DEFAULT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       ir_write,
  output logic       epc_write,
  output logic       reg_write,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [1:0] alu_ctrl,
  output logic [1:0] exc_cause,
  output logic       busy
`ifdef PC_SEQ_EXC_COUNT_EN
  ,
  output logic [7:0] exc_count
`endif
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(MEM_LAT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] fcnt;
  logic [1:0]       cause_q, cause_pend, cause_pend_nxt;
  logic             fetch_done;
  logic             pc_we, ir_we, epc_we, reg_we;

  assign fetch_done = (state == FETCH) && (fcnt == FETCH_LAST);

  // The cause is picked when the fault is seen and committed while EPC is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      fcnt       <= '0;
      cause_q    <= CAUSE_NONE;
      cause_pend <= CAUSE_NONE;
    end else begin
      state      <= state_nxt;
      cause_pend <= cause_pend_nxt;
      if (state == FETCH) begin
        fcnt <= fetch_done ? '0 : fcnt + CNT_W'(1);
      end
      if (state == EXC_SAVE) begin
        cause_q <= cause_pend;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cause_pend_nxt = cause_pend;
    pc_source      = PCS_ALU;
    pc_we          = 1'b0;
    ir_we          = 1'b0;
    epc_we         = 1'b0;
    reg_we         = 1'b0;
    alu_srca       = 1'b0;
    alu_srcb       = SRCB_FOUR;
    alu_ctrl       = ALU_ADD;
    case (state)
      FETCH: begin
        if (fetch_done) begin
          pc_we     = 1'b1;
          ir_we     = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        alu_srcb = SRCB_IMM;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_SUB) begin
              state_nxt = EXEC;
            end else if (funct == FN_RTE) begin
              state_nxt = RTE;
            end else begin
              state_nxt      = EXC_SAVE;
              cause_pend_nxt = CAUSE_ILLEGAL;
            end
          end
          OP_BEQ, OP_BNE: state_nxt = BRANCH;
          OP_J:           state_nxt = JUMP;
          default: begin
            state_nxt      = EXC_SAVE;
            cause_pend_nxt = CAUSE_ILLEGAL;
          end
        endcase
      end
      EXEC: begin
        alu_srca = 1'b1;
        alu_srcb = SRCB_REGB;
        alu_ctrl = alu_op_of_funct(funct);
        if (overflow) begin
          state_nxt      = EXC_SAVE;
          cause_pend_nxt = CAUSE_OVF;
        end else begin
          state_nxt = WB;
        end
      end
      WB: begin
        alu_srca  = 1'b1;
        alu_srcb  = SRCB_REGB;
        alu_ctrl  = alu_op_of_funct(funct);
        reg_we    = WB_EN_DEFAULT;
        state_nxt = FETCH;
      end
      BRANCH: begin
        alu_srca  = 1'b1;
        alu_srcb  = SRCB_REGB;
        alu_ctrl  = ALU_SUB;
        pc_source = PCS_ALUOUT;
        pc_we     = (opcode == OP_BNE) ? !zero : zero;
        state_nxt = FETCH;
      end
      JUMP: begin
        pc_source = PCS_JUMP;
        pc_we     = 1'b1;
        state_nxt = FETCH;
      end
      RTE: begin
        pc_source = PCS_EPC;
        pc_we     = 1'b1;
        state_nxt = FETCH;
      end
      EXC_SAVE: begin
        alu_ctrl  = ALU_SUB;
        epc_we    = 1'b1;
        state_nxt = EXC_VEC;
      end
      EXC_VEC: begin
        alu_srcb  = SRCB_VEC;
        alu_ctrl  = ALU_PASSB;
        pc_we     = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Gating with reset keeps a single-cycle fetch from writing PC/IR while held in reset.
  assign pc_write  = pc_we & reset_n;
  assign ir_write  = ir_we & reset_n;
  assign epc_write = epc_we & reset_n;
  assign reg_write = reg_we & reset_n;
  assign exc_cause = cause_q;
  assign busy      = (state != FETCH);

`ifdef PC_SEQ_EXC_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exc_count <= 8'h00;
    end else if (state_nxt == EXC_SAVE && state != EXC_SAVE && exc_count != 8'hFF) begin
      exc_count <= exc_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multicycle control FSM that sequences PC updates for the MIPS-subset datapath. It drives the 2-bit PC-source select (00 ALU result, 01 ALUOut, 10 jump target, 11 EPC), the PC/IR/EPC write enables and the ALU operand selects. It covers fetch, branch, jump, return-from-exception and arithmetic-exception entry. It sits beside the datapath and replaces ad-hoc PC-source decoding.

Parameters:
MEM_LAT, 2, fetch cycles before the instruction word is valid (>=1)
WB_EN_DEFAULT, 1, reg_write polarity sanity: 1 = active-high (fixed; no other value legal)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag (combinational, current cycle)
overflow  input  1  ALU signed overflow (combinational, current cycle)
pc_source  output  2  PC mux select
pc_write  output  1  load PC
ir_write  output  1  load IR
epc_write  output  1  load EPC from ALU result
reg_write  output  1  register-file write
alu_srca  output  1  0=PC, 1=reg A
alu_srcb  output  2  00=reg B, 01=const 4, 10=exception vector, 11=signext<<2
alu_ctrl  output  2  00=ADD, 01=SUB, 10=PASS_B
exc_cause  output  2  00 none, 01 invalid opcode, 10 overflow; held until next exception
busy  output  1  high in every state except FETCH

Behaviour:
- Reset (async assert, sync deassert on next clk edge): state=FETCH, wait counter=0, exc_cause=00; all write enables 0; pc_source=00, alu_srca=0, alu_srcb=01, alu_ctrl=ADD.
- Outputs are Moore-decoded from state, except pc_write in BRANCH (depends on zero).
- FETCH: srca=0, srcb=01, ADD, pc_source=00. Counter increments each cycle; on the cycle counter==MEM_LAT-1, assert pc_write and ir_write, clear counter, go to DECODE. MEM_LAT=1: single fetch cycle.
- DECODE: srca=0, srcb=11, ADD (branch target captured into ALUOut by the datapath). Dispatch:
  - opcode 00 with funct 20 (add) or 22 (sub) -> EXEC
  - opcode 00 with funct 13 (rte) -> RTE
  - opcode 04/05 -> BRANCH
  - opcode 02 -> JUMP
  - anything else -> EXC_SAVE with cause=01
- EXEC: srca=1, srcb=00, ADD/SUB per funct. overflow=1 -> EXC_SAVE with cause=10; else -> WB.
- WB: reg_write=1, ALU held as in EXEC -> FETCH. No write on overflow.
- BRANCH: srca=1, srcb=00, SUB, pc_source=01. pc_write = zero (beq) or !zero (bne) -> FETCH.
- JUMP: pc_source=10, pc_write=1 -> FETCH.
- RTE: pc_source=11, pc_write=1 -> FETCH. exc_cause unchanged.
- EXC_SAVE: srca=0, srcb=01, SUB (PC-4 = faulting instruction), epc_write=1; exc_cause loaded this cycle -> EXC_VEC.
- EXC_VEC: srcb=10, PASS_B, pc_source=00, pc_write=1 -> FETCH.
- Exceptions are not nested: none can arise in EXC_*.
- Reset mid-instruction aborts immediately, with no partial PC/EPC write.
- pc_write, ir_write, epc_write and reg_write are never asserted together, except pc_write+ir_write in FETCH.

Optional Feature:
PC_SEQ_EXC_COUNT_EN: when defined, adds output exc_count[7:0]. It resets to 0, increments on entry to EXC_SAVE and saturates at 8'hFF. When undefined, the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum (FETCH, DECODE, EXEC, WB, BRANCH, JUMP, RTE, EXC_SAVE, EXC_VEC)
  - PC-source encodings
  - alu_srcb and alu_ctrl encodings
  - opcode/funct constants
  - cause codes
- No sub-module; the fetch wait counter stays inline.

Test Plan:
- Reset: pulse reset_n low mid-EXEC -> all enables 0 immediately, state FETCH; after release, pc_write+ir_write pulse on fetch cycle 2 (MEM_LAT=2).
- beq: opcode 04, zero=1 in BRANCH -> pc_source=01, pc_write=1 for one cycle. Same with zero=0 -> pc_write=0. bne inverted.
- j: opcode 02 -> DECODE then JUMP with pc_source=10, pc_write=1; back in FETCH on the next cycle.
- add with overflow=1 in EXEC -> no reg_write; EXC_SAVE epc_write=1 with SUB/srcb=01; exc_cause=10; EXC_VEC pc_source=00, srcb=10, pc_write=1.
- opcode 3F -> exc_cause=01, EPC written; then rte (00/13) -> pc_source=11, pc_write=1, exc_cause still 01.
- PC_SEQ_EXC_COUNT_EN defined: 257 illegal opcodes -> exc_count=FF, no wrap.
